dec_scan: RTL
=============

# dec_scan

Parametrised, registered binary-to-one-hot decoder with enable. It generalises the fixed 3-to-8 decoder to IN_W select bits and NUM_CH active channels, and adds an autonomous scan mode that steps the active output through the channels at a programmable rate. The scan mode drives multiplexed displays and LED banks. It sits between control logic or a register file and the multiplexed output drivers.

## Interface
Parameters:
- IN_W, 3, select width; output width is 2**IN_W.
- NUM_CH, 8, number of used channels; 1 ≤ NUM_CH ≤ 2**IN_W; scan wraps after channel NUM_CH-1.
- DIV, 4, clocks per scan step; DIV ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  output enable; 0 forces all outputs inactive.
- mode  in  1  0 = direct (decode loaded select), 1 = scan.
- load  in  1  strobe: capture sel into the index register.
- sel  in  IN_W  requested channel.
- out  out  2**IN_W  one-hot channel drive, registered.
- idx  out  IN_W  current channel index, registered.
- wrap  out  1  one-cycle pulse when the scan index wraps to 0.
- err  out  1  one-cycle pulse when a load requests sel ≥ NUM_CH.

## Operation
- Internal state: idx register, prescaler cnt (width clog2(DIV), minimum 1 bit), and the out, wrap and err registers.
- Reset (async, immediate): idx=0, cnt=0, out=0, wrap=0, err=0.
- Next index idx_n is evaluated each rising edge, in priority order:
  - load=1 and sel < NUM_CH: idx_n = sel, cnt <= 0 (applies in both modes; re-synchronises the scan).
  - load=1 and sel ≥ NUM_CH: idx_n = idx, err <= 1, cnt <= 0.
  - mode=1, en=1, no load: cnt increments. When cnt == DIV-1, cnt <= 0 and idx_n = (idx == NUM_CH-1) ? 0 : idx+1. A wrap to 0 sets wrap <= 1.
  - mode=0, no load: idx holds, cnt <= 0.
- out <= en ? (1 << idx_n) : 0. Exactly one bit of out is set whenever en=1 (inverted sense under the macro).
- en=0: out <= 0; idx still accepts loads; cnt and scan stepping freeze (held); wrap stays 0.
- wrap and err are 0 on every cycle other than their event cycle.
- Mode change takes effect at the next edge. Entering scan starts from cnt=0, so the first step occurs DIV clocks after mode rises.
- DIV=1: idx advances every clock in scan mode.
- NUM_CH=1: scan holds idx=0 and pulses wrap every DIV clocks.

## Timing
- Load latency: load/sel sampled at edge k; idx and out are valid after edge k, i.e. one clock of latency.
- Scan: each channel is active for exactly DIV clocks. Full period is NUM_CH*DIV clocks.
- wrap is asserted in the same cycle that idx first reads 0 after NUM_CH-1.
- en deassert takes effect at the next edge (out=0 one clock later). On re-assert, out shows the held idx one clock later.
- Asynchronous reset mid-scan clears out within the reset assertion, with no clock required. Operation resumes from idx=0 and cnt=0 on the first edge after rst falls.

## Configuration
- DEC_SCAN_ACTIVE_LOW_EN defined: out is active-low (for common-anode drive).
  - Active channel reads 0 and the others read 1.
  - en=0 and reset drive out to all ones.
- DEC_SCAN_ACTIVE_LOW_EN undefined: active-high as described above; reset and en=0 give all zeros.
- idx, wrap and err are unaffected by the macro.

## Test plan
- Reset, then direct decode (IN_W=3, NUM_CH=8, mode=0, en=1): load sel=0..7 in turn; after each edge idx=sel and out=1<<sel (8'b0000_0001 … 8'b1000_0000). With en=0, out=8'h00 for every sel.
- Range check (NUM_CH=6): load sel=7 while idx=2; idx stays 2, out=8'b0000_0100, err pulses for exactly one cycle.
- Scan (DIV=4, NUM_CH=6): with mode=1, idx steps 0,1,2,3,4,5,0, each held 4 clocks. wrap is high for one cycle with idx=0, every 24 clocks.
- Simultaneous load during scan: load sel=3 on the cycle cnt==DIV-1. idx becomes 3 (load wins over the step), cnt=0, and the next step to 4 occurs 4 clocks later.
- en toggle mid-scan: deassert en for 10 clocks at idx=2, cnt=1; out=0 and idx/cnt frozen. On re-assert, out=8'b0000_0100 and the step to 3 comes 3 clocks later.
- Async reset mid-scan (idx=4): raise rst between edges; out, idx, wrap and err clear immediately (out=all ones with DEC_SCAN_ACTIVE_LOW_EN). Repeat the scan check in both macro builds.

Source files
------------

// File: rtl/dec_scan.sv
// Registered binary-to-one-hot decoder with enable, range check and autonomous scan mode.
// Optional build macro DEC_SCAN_ACTIVE_LOW_EN inverts the polarity of out (active-low channel drive).
module dec_scan #(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [IN_W-1:0]       sel,
  output logic [(1<<IN_W)-1:0]  out,
  output logic [IN_W-1:0]       idx,
  output logic                  wrap,
  output logic                  err
);

  localparam int unsigned OUT_W = 1 << IN_W;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IN_W:0]      SEL_LIM  = (IN_W+1)'(NUM_CH);
  localparam logic [IN_W-1:0]    LAST_CH  = IN_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);

`ifdef DEC_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0]   OFF_VAL  = '1;
`else
  localparam logic [OUT_W-1:0]   OFF_VAL  = '0;
`endif

  logic [IN_W-1:0]  idx_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [OUT_W-1:0] out_n;
  logic [OUT_W-1:0] onehot;
  logic             wrap_n;
  logic             err_n;

  // State registers; reset drives the inactive output pattern immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      out  <= OFF_VAL;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      idx  <= idx_n;
      cnt  <= cnt_n;
      out  <= out_n;
      wrap <= wrap_n;
      err  <= err_n;
    end
  end

  // Next index: load beats a scan step; out-of-range loads keep idx and flag err
  always_comb begin
    idx_n  = idx;
    cnt_n  = cnt;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (load) begin
      cnt_n = '0;
      if ({1'b0, sel} < SEL_LIM) begin
        idx_n = sel;
      end else begin
        err_n = 1'b1;
      end
    end else if (mode) begin
      // Disabled scan freezes both the prescaler and the index
      if (en) begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (idx == LAST_CH) begin
            idx_n  = '0;
            wrap_n = 1'b1;
          end else begin
            idx_n = idx + IN_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end else begin
      cnt_n = '0;
    end
  end

  // Output decode follows the index being loaded this edge
  always_comb begin
    onehot = OUT_W'(1) << idx_n;
    out_n  = OFF_VAL;
    if (en) begin
      out_n = onehot ^ OFF_VAL;
    end
  end

endmodule
